// File: rtl/experiment_emulator_pkg.sv
// ============================================================================
// Module  : types_pkg
// Brief   : Shared state encodings and LFSR helpers for experiment_emulator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package types_pkg;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_DELAY  = 2'd1,
    W_BROKEN = 2'd2
  } wire_state_t;

  typedef enum logic [0:0] {
    D_READY = 1'b0,
    D_BUSY  = 1'b1
  } det_state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10)
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/experiment_emulator_oneshot_timer.sv
// ============================================================================
// Module  : emu_oneshot_timer
// Brief   : Loadable down-counter; done is high during the last counted clock.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module emu_oneshot_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset_signal,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             done
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset_signal) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A load of N keeps the owner busy for exactly N clocks.
  assign done = (count_q == CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/experiment_emulator.sv
// ============================================================================
// Module  : experiment_emulator
// Brief   : Frame-grabber pulse generator, broken-wire and detector emulation.
//           Define EXPERIMENT_EMULATOR_JITTER_EN to add LFSR frame jitter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module experiment_emulator
  import types_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int OPTO_LEN = 20,
  parameter int OPEN_LEN = 20
) (
  input  logic             clock,
  input  logic             reset_signal,
  input  logic             enable,
  input  logic [CNT_W-1:0] fg_period,
  input  logic [CNT_W-1:0] fg_open_delay,
  input  logic [CNT_W-1:0] wire_delay,
  input  logic [CNT_W-1:0] detector_prolong,
  input  logic             rearm,
  input  logic             detonator_triggered,
  input  logic             output_trigger,
  output logic             fg_opto,
  output logic             fg_open,
  output logic             wire_sensor,
  output logic             detector_ready,
  output logic [15:0]      frame_count,
  output logic [7:0]       overrun_count
);

  localparam int PW = CNT_W + 1;

  logic [CNT_W-1:0] phase_q, phase_d;
  logic [PW-1:0]    period_q, period_d;
  logic [CNT_W-1:0] open_delay_q, open_delay_d;
  logic [15:0]      frame_count_q, frame_count_d;
  logic             fg_opto_q, fg_opto_d, fg_open_q, fg_open_d;
  logic             frame_start;
  logic [PW-1:0]    base_period, cur_period;
  logic [CNT_W-1:0] cur_delay;
  logic [2:0]       jitter;

  logic             det_prev_q, trig_prev_q;
  logic             det_edge, trig_edge;
  wire_state_t      wire_state_q, wire_state_d;
  det_state_t       det_state_q, det_state_d;
  logic             wire_load, wire_done, det_load, det_done;
  logic [7:0]       overrun_q, overrun_d;

  assign frame_start = enable && (phase_q == '0);
  assign base_period = (fg_period < CNT_W'(2)) ? PW'(2) : {1'b0, fg_period};

`ifdef EXPERIMENT_EMULATOR_JITTER_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign jitter = lfsr_q[2:0];

  always_comb begin
    lfsr_d = lfsr_q;
    if (frame_start) begin
      lfsr_d = lfsr_step(lfsr_q);
    end
  end

  always_ff @(posedge clock) begin
    if (reset_signal) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign jitter = 3'd0;
`endif

  // Frame parameters are taken live on the frame-start clock, then held.
  always_comb begin
    cur_period    = frame_start ? (base_period + PW'(jitter)) : period_q;
    cur_delay     = frame_start ? fg_open_delay : open_delay_q;
    period_d      = cur_period;
    open_delay_d  = cur_delay;
    phase_d       = '0;
    frame_count_d = frame_count_q;
    fg_opto_d     = 1'b0;
    fg_open_d     = 1'b0;
    if (enable) begin
      if (frame_start) begin
        frame_count_d = frame_count_q + 16'd1;
      end
      if ({1'b0, phase_q} != (cur_period - PW'(1))) begin
        phase_d = phase_q + CNT_W'(1);
      end
      fg_opto_d = (phase_q < CNT_W'(OPTO_LEN));
      fg_open_d = (phase_q >= cur_delay) && ((phase_q - cur_delay) < CNT_W'(OPEN_LEN));
    end
  end

  assign det_edge  = detonator_triggered & ~det_prev_q;
  assign trig_edge = output_trigger & ~trig_prev_q;

  always_comb begin
    wire_state_d = wire_state_q;
    wire_load    = 1'b0;
    case (wire_state_q)
      W_IDLE: begin
        if (det_edge) begin
          if (wire_delay == '0) begin
            wire_state_d = W_BROKEN;
          end else begin
            wire_state_d = W_DELAY;
            wire_load    = 1'b1;
          end
        end
      end
      W_DELAY:  if (wire_done) wire_state_d = W_BROKEN;
      W_BROKEN: wire_state_d = W_BROKEN;
      default:  wire_state_d = W_IDLE;
    endcase
    if (rearm) begin
      wire_state_d = W_IDLE;
      wire_load    = 1'b0;
    end
  end

  always_comb begin
    det_state_d = det_state_q;
    det_load    = 1'b0;
    overrun_d   = overrun_q;
    if (det_state_q == D_READY) begin
      if (trig_edge && (detector_prolong != '0)) begin
        det_state_d = D_BUSY;
        det_load    = 1'b1;
      end
    end else begin
      if (trig_edge && (overrun_q != 8'hFF)) begin
        overrun_d = overrun_q + 8'd1;
      end
      if (det_done) begin
        det_state_d = D_READY;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset_signal) begin
      phase_q       <= '0;
      period_q      <= PW'(2);
      open_delay_q  <= '0;
      frame_count_q <= '0;
      fg_opto_q     <= 1'b0;
      fg_open_q     <= 1'b0;
      det_prev_q    <= 1'b0;
      trig_prev_q   <= 1'b0;
      wire_state_q  <= W_IDLE;
      det_state_q   <= D_READY;
      overrun_q     <= '0;
    end else begin
      phase_q       <= phase_d;
      period_q      <= period_d;
      open_delay_q  <= open_delay_d;
      frame_count_q <= frame_count_d;
      fg_opto_q     <= fg_opto_d;
      fg_open_q     <= fg_open_d;
      det_prev_q    <= detonator_triggered;
      trig_prev_q   <= output_trigger;
      wire_state_q  <= wire_state_d;
      det_state_q   <= det_state_d;
      overrun_q     <= overrun_d;
    end
  end

  emu_oneshot_timer #(.CNT_W(CNT_W)) u_wire_timer (
    .clock        (clock),
    .reset_signal (reset_signal),
    .load         (wire_load),
    .load_value   (wire_delay),
    .done         (wire_done)
  );

  emu_oneshot_timer #(.CNT_W(CNT_W)) u_det_timer (
    .clock        (clock),
    .reset_signal (reset_signal),
    .load         (det_load),
    .load_value   (detector_prolong),
    .done         (det_done)
  );

  assign fg_opto        = fg_opto_q;
  assign fg_open        = fg_open_q;
  assign wire_sensor    = (wire_state_q == W_BROKEN);
  assign detector_ready = (det_state_q == D_READY);
  assign frame_count    = frame_count_q;
  assign overrun_count  = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_experiment_emulator.sv
// ============================================================================
// Module  : tb_experiment_emulator
// Brief   : Scoreboard bench for experiment_emulator (directed vectors).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_experiment_emulator;

  localparam int CNT_W = 32;
  localparam int S_OPTO = 0, S_OPEN = 1, S_WIRE = 2, S_RDY = 3, S_FRM = 4, S_OVR = 5;

  logic             clock = 1'b0;
  logic             reset_signal = 1'b1;
  logic             enable = 1'b0;
  logic [CNT_W-1:0] fg_period = '0;
  logic [CNT_W-1:0] fg_open_delay = '0;
  logic [CNT_W-1:0] wire_delay = '0;
  logic [CNT_W-1:0] detector_prolong = '0;
  logic             rearm = 1'b0;
  logic             detonator_triggered = 1'b0;
  logic             output_trigger = 1'b0;
  logic             fg_opto, fg_open, wire_sensor, detector_ready;
  logic [15:0]      frame_count;
  logic [7:0]       overrun_count;

  always #5 clock = ~clock;

  experiment_emulator #(.CNT_W(CNT_W), .OPTO_LEN(20), .OPEN_LEN(20)) dut (
    .clock               (clock),
    .reset_signal        (reset_signal),
    .enable              (enable),
    .fg_period           (fg_period),
    .fg_open_delay       (fg_open_delay),
    .wire_delay          (wire_delay),
    .detector_prolong    (detector_prolong),
    .rearm               (rearm),
    .detonator_triggered (detonator_triggered),
    .output_trigger      (output_trigger),
    .fg_opto             (fg_opto),
    .fg_open             (fg_open),
    .wire_sensor         (wire_sensor),
    .detector_ready      (detector_ready),
    .frame_count         (frame_count),
    .overrun_count       (overrun_count)
  );

  typedef struct {
    int    cyc;
    int    sig;
    int    val;
    string name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic int sample(input int s);
    case (s)
      S_OPTO:  return int'(fg_opto);
      S_OPEN:  return int'(fg_open);
      S_WIRE:  return int'(wire_sensor);
      S_RDY:   return int'(detector_ready);
      S_FRM:   return int'(frame_count);
      default: return int'(overrun_count);
    endcase
  endfunction

  function automatic void expect_at(input int c, input int s, input int v, input string n);
    sb.push_back('{c, s, v, n});
  endfunction

  function automatic logic [15:0] ref_lfsr(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Monitor: outputs are registered, so the falling edge sees settled values.
  initial begin : monitor
    int act;
    forever begin
      @(negedge clock);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc <= cyc) begin
          n_checks++;
          act = sample(sb[i].sig);
          if (sb[i].cyc < cyc) begin
            n_fail++;
            $display("FAIL %s: check for cycle %0d missed at cycle %0d", sb[i].name, sb[i].cyc, cyc);
          end else if (act != sb[i].val) begin
            n_fail++;
            $display("FAIL %s: cycle %0d got %0d expected %0d", sb[i].name, cyc, act, sb[i].val);
          end
          sb.delete(i);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic go(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  task automatic pulse_reset();
    reset_signal = 1'b1;
    step(1);
    reset_signal = 1'b0;
    step(1);
  endtask

  initial begin : stim
    int t, s, e, r, guard, len, start;
    logic [15:0] l;

    // Reset state
    step(1);
    t = cyc;
    expect_at(t + 1, S_OPTO, 0, "rst_opto");
    expect_at(t + 1, S_OPEN, 0, "rst_open");
    expect_at(t + 1, S_WIRE, 0, "rst_wire");
    expect_at(t + 1, S_RDY,  1, "rst_ready");
    expect_at(t + 1, S_FRM,  0, "rst_frame");
    expect_at(t + 1, S_OVR,  0, "rst_overrun");
    step(2);
    reset_signal = 1'b0;

    // Frame generator, period 2000, open delay 400
    fg_period = 2000; fg_open_delay = 400;
    step(1);
    t = cyc; enable = 1'b1; s = t + 1;
    expect_at(s,        S_OPTO, 1, "opto_rise");
    expect_at(s + 19,   S_OPTO, 1, "opto_last");
    expect_at(s + 20,   S_OPTO, 0, "opto_fall");
    expect_at(s + 399,  S_OPEN, 0, "open_before");
    expect_at(s + 400,  S_OPEN, 1, "open_rise");
    expect_at(s + 419,  S_OPEN, 1, "open_last");
    expect_at(s + 420,  S_OPEN, 0, "open_fall");
    expect_at(s,        S_FRM,  1, "frame1");
    expect_at(s + 1999, S_FRM,  1, "frame1_end");
    expect_at(s + 1999, S_OPTO, 0, "opto_gap");
    expect_at(s + 2000, S_FRM,  2, "frame2");
    expect_at(s + 2000, S_OPTO, 1, "opto_frame2");
    go(s + 50);
    fg_open_delay = 100;
    go(s + 2004);
    enable = 1'b0;
    expect_at(cyc + 1, S_OPTO, 0, "disable_opto");
    expect_at(cyc + 1, S_FRM,  2, "disable_frame_hold");
    step(4);
    t = cyc; enable = 1'b1;
    expect_at(t + 1, S_OPTO, 1, "reenable_opto");
    expect_at(t + 1, S_FRM,  3, "reenable_frame");
    go(t + 3);
    enable = 1'b0;
    step(2);

    // Wire FSM, delay 100
    wire_delay = 100;
    t = cyc; detonator_triggered = 1'b1; e = t + 1;
    expect_at(e,       S_WIRE, 0, "wire_start");
    expect_at(e + 99,  S_WIRE, 0, "wire_before");
    expect_at(e + 100, S_WIRE, 1, "wire_broken");
    expect_at(e + 150, S_WIRE, 1, "wire_stays");
    go(e + 10); detonator_triggered = 1'b0;
    go(e + 20); detonator_triggered = 1'b1; wire_delay = 5;
    go(e + 120); detonator_triggered = 1'b0;
    go(e + 125); detonator_triggered = 1'b1;
    go(e + 160);
    rearm = 1'b1;
    expect_at(cyc + 1, S_WIRE, 0, "rearm_clear");
    step(1); rearm = 1'b0;
    detonator_triggered = 1'b0; wire_delay = 0;
    step(2);
    t = cyc; rearm = 1'b1; detonator_triggered = 1'b1;
    expect_at(t + 1, S_WIRE, 0, "rearm_wins");
    expect_at(t + 3, S_WIRE, 0, "edge_dropped");
    step(1); rearm = 1'b0;
    step(3); detonator_triggered = 1'b0;
    step(2);
    t = cyc; detonator_triggered = 1'b1;
    expect_at(t + 1, S_WIRE, 1, "wire_zero_delay");
    step(3);
    rearm = 1'b1; step(1); rearm = 1'b0; detonator_triggered = 1'b0;
    step(2);

    // Detector FSM, prolong 1280, three overrun edges
    detector_prolong = 1280;
    t = cyc; output_trigger = 1'b1; e = t + 1;
    expect_at(e,        S_RDY, 0, "det_busy");
    expect_at(e + 1279, S_RDY, 0, "det_last_busy");
    expect_at(e + 1280, S_RDY, 1, "det_ready_again");
    expect_at(e + 100,  S_OVR, 3, "overrun3");
    for (int k = 0; k < 3; k++) begin
      go(e + 10 + 20 * k); output_trigger = 1'b0;
      go(e + 20 + 20 * k); output_trigger = 1'b1;
    end
    go(e + 80); output_trigger = 1'b0; detector_prolong = 5;
    go(e + 1300);
    detector_prolong = 0;
    t = cyc; output_trigger = 1'b1;
    expect_at(t + 1, S_RDY, 1, "prolong_zero");
    expect_at(t + 1, S_OVR, 3, "overrun_hold");
    step(2); output_trigger = 1'b0;
    step(2);

    // Reset in the middle of W_DELAY and D_BUSY
    wire_delay = 100; detector_prolong = 1280;
    t = cyc; enable = 1'b1; detonator_triggered = 1'b1; output_trigger = 1'b1; e = t + 1;
    go(e + 50);
    r = cyc; reset_signal = 1'b1; detonator_triggered = 1'b0; output_trigger = 1'b0;
    expect_at(r + 1, S_WIRE, 0, "mid_rst_wire");
    expect_at(r + 1, S_RDY,  1, "mid_rst_ready");
    expect_at(r + 1, S_FRM,  0, "mid_rst_frame");
    expect_at(r + 1, S_OVR,  0, "mid_rst_overrun");
    expect_at(r + 1, S_OPTO, 0, "mid_rst_opto");
    expect_at(r + 2, S_FRM,  1, "post_rst_frame");
    expect_at(r + 2, S_OPTO, 1, "post_rst_opto");
    expect_at(e + 100, S_WIRE, 0, "wire_aborted");
    expect_at(e + 200, S_RDY,  1, "det_aborted");
    step(1); reset_signal = 1'b0;
    go(e + 210); enable = 1'b0;
    step(2);

    // fg_period = 1 behaves as 2
    pulse_reset();
    fg_period = 1; fg_open_delay = 0;
    t = cyc; enable = 1'b1; s = t + 1;
    expect_at(s,     S_OPTO, 1, "p1_opto0");
    expect_at(s + 1, S_OPTO, 1, "p1_opto1");
    expect_at(s + 1, S_OPEN, 1, "p1_open");
    expect_at(s + 1, S_FRM,  1, "p1_frame_a");
    expect_at(s + 2, S_FRM,  2, "p1_frame_b");
    expect_at(s + 9, S_FRM,  5, "p1_frame_c");
    go(s + 10); enable = 1'b0;
    step(2);

    // Open delay equal to period; period change takes effect next frame
    pulse_reset();
    fg_period = 50; fg_open_delay = 50;
    t = cyc; enable = 1'b1; s = t + 1;
    for (int i = 0; i < 50; i++) expect_at(s + i, S_OPEN, 0, "open_never");
    expect_at(s + 49,  S_OPTO, 0, "p50_end");
    expect_at(s + 50,  S_OPTO, 1, "p50_frame2");
    expect_at(s + 50,  S_FRM,  2, "p50_frame2_cnt");
    expect_at(s + 109, S_OPTO, 0, "p60_gap");
    expect_at(s + 109, S_OPEN, 1, "open_clip_last");
    expect_at(s + 110, S_OPEN, 0, "open_clip_end");
    expect_at(s + 110, S_OPTO, 1, "p60_frame3");
    expect_at(s + 110, S_FRM,  3, "p60_frame3_cnt");
    go(s + 10); fg_period = 60;
    go(s + 112); enable = 1'b0;
    step(2);

    // Overrun saturation after 256 edges in one busy window
    pulse_reset();
    detector_prolong = 2000;
    t = cyc; output_trigger = 1'b1; e = t + 1;
    expect_at(e + 20,  S_OVR, 10,  "ovr_10");
    expect_at(e + 508, S_OVR, 254, "ovr_254");
    expect_at(e + 510, S_OVR, 255, "ovr_255");
    expect_at(e + 512, S_OVR, 255, "ovr_sat");
    expect_at(e + 515, S_OVR, 255, "ovr_sat_hold");
    expect_at(e + 515, S_RDY, 0,   "ovr_still_busy");
    step(1);
    for (int k = 0; k < 256; k++) begin
      output_trigger = 1'b0; step(1);
      output_trigger = 1'b1; step(1);
    end
    output_trigger = 1'b0;
    step(4);

    // Frame lengths with/without jitter, period 1000
    pulse_reset();
    fg_period = 1000; fg_open_delay = 400;
    t = cyc; enable = 1'b1; start = t + 1;
    l = 16'hACE1;
    for (int f = 0; f < 4; f++) begin
      expect_at(start, S_OPTO, 1, "jit_frame_start");
      expect_at(start, S_FRM, f + 1, "jit_frame_cnt");
      if (f > 0) expect_at(start - 1, S_OPTO, 0, "jit_frame_prev_end");
`ifdef EXPERIMENT_EMULATOR_JITTER_EN
      len = 1000 + int'(l[2:0]);
`else
      len = 1000;
`endif
      l = ref_lfsr(l);
      start = start + len;
    end
    go(start - len + 2);
    enable = 1'b0;

    guard = 0;
    while (sb.size() > 0 && guard < 5000) begin
      step(1);
      guard++;
    end
    while (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: never checked (cycle %0d pending)", sb[0].name, sb[0].cyc);
      sb.delete(0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
